// File: rtl/wb_queue.sv
// Writeback queue: merges execute and load results in program order, drains one register write
// per cycle and flags source hazards. Optional WB_FWD_EN macro adds youngest-match forwarding.
module wb_queue #(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       exe_valid_i,
  input  logic [3:0]                 exe_dest_i,
  input  logic [31:0]                exe_result_i,
  input  logic                       mem_valid_i,
  output logic                       mem_ready_o,
  input  logic [3:0]                 mem_dest_i,
  input  logic [31:0]                mem_data_i,
  input  logic [3:0]                 src1_i,
  input  logic [3:0]                 src2_i,
  output logic                       hazard1_o,
  output logic                       hazard2_o,
  output logic                       stall_o,
  output logic [3:0]                 dest_wb_o,
  output logic [31:0]                result_wb_o,
  output logic                       write_back_en_o,
`ifdef WB_FWD_EN
  output logic                       fwd1_valid_o,
  output logic [31:0]                fwd1_data_o,
  output logic                       fwd2_valid_o,
  output logic [31:0]                fwd2_data_o,
`endif
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(Depth);

  logic [3:0]    dest_q [Depth];
  logic [31:0]   data_q [Depth];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, exe_idx;
  logic [CW-1:0] count_q, count_d, occ_after_exe;
  logic          mem_push, exe_push, pop;
  logic          stall_q, wb_en_q;
  logic [3:0]    dest_wb_q;
  logic [31:0]   result_wb_q;
  logic          match1, match2;
`ifdef WB_FWD_EN
  logic [31:0]   fwd1_data, fwd2_data;
`endif

  always_comb begin
    occ_after_exe = count_q + CW'(exe_valid_i);
    mem_ready_o   = mem_valid_i && (occ_after_exe < DepthC);
    // PC-destined results are consumed but never occupy a slot
    mem_push      = mem_ready_o && (mem_dest_i != 4'hF);
    exe_push      = exe_valid_i && (exe_dest_i != 4'hF) && (count_q != DepthC);
    pop           = (count_q != '0);
    exe_idx       = tail_q + AW'(mem_push);
    tail_d        = tail_q + AW'(mem_push) + AW'(exe_push);
    head_d        = head_q + AW'(pop);
    count_d       = count_q + CW'(mem_push) + CW'(exe_push) - CW'(pop);
  end

  // Scan oldest to youngest so the last match is the youngest
  always_comb begin
    logic [AW-1:0] idx;
    match1 = 1'b0;
    match2 = 1'b0;
`ifdef WB_FWD_EN
    fwd1_data = '0;
    fwd2_data = '0;
`endif
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = head_q + AW'(i);
      if (CW'(i) < count_q) begin
        if (dest_q[idx] == src1_i) begin
          match1 = 1'b1;
`ifdef WB_FWD_EN
          fwd1_data = data_q[idx];
`endif
        end
        if (dest_q[idx] == src2_i) begin
          match2 = 1'b1;
`ifdef WB_FWD_EN
          fwd2_data = data_q[idx];
`endif
        end
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd1_valid_o = match1;
  assign fwd1_data_o  = fwd1_data;
  assign fwd2_valid_o = match2;
  assign fwd2_data_o  = fwd2_data;
  assign hazard1_o    = 1'b0;
  assign hazard2_o    = 1'b0;
`else
  assign hazard1_o    = match1;
  assign hazard2_o    = match2;
`endif

  always_ff @(posedge clk_i) begin
    if (mem_push) begin
      dest_q[tail_q] <= mem_dest_i;
      data_q[tail_q] <= mem_data_i;
    end
    if (exe_push) begin
      dest_q[exe_idx] <= exe_dest_i;
      data_q[exe_idx] <= exe_result_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      stall_q     <= 1'b0;
      wb_en_q     <= 1'b0;
      dest_wb_q   <= '0;
      result_wb_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= (count_d > DepthC - CW'(2));
      wb_en_q <= pop;
      if (pop) begin
        dest_wb_q   <= dest_q[head_q];
        result_wb_q <= data_q[head_q];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    assert (!(rst_ni && exe_valid_i && (count_q == DepthC)))
      else $error("wb_queue: execute result dropped, queue full");
  end

  assign stall_o         = stall_q;
  assign write_back_en_o = wb_en_q;
  assign dest_wb_o       = dest_wb_q;
  assign result_wb_o     = result_wb_q;
  assign count_o         = count_q;

endmodule

// File: tb/tb_wb_queue.sv
// Directed testbench for wb_queue (Depth=4) with hand-computed expected values.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valid, mem_valid, mem_ready;
  logic [3:0]  exe_dest, mem_dest, src1, src2, dest_wb;
  logic [31:0] exe_result, mem_data, result_wb;
  logic        hazard1, hazard2, stall, wb_en;
  logic [2:0]  count;
`ifdef WB_FWD_EN
  logic        fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_queue #(.Depth(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .exe_valid_i     (exe_valid),
    .exe_dest_i      (exe_dest),
    .exe_result_i    (exe_result),
    .mem_valid_i     (mem_valid),
    .mem_ready_o     (mem_ready),
    .mem_dest_i      (mem_dest),
    .mem_data_i      (mem_data),
    .src1_i          (src1),
    .src2_i          (src2),
    .hazard1_o       (hazard1),
    .hazard2_o       (hazard2),
    .stall_o         (stall),
    .dest_wb_o       (dest_wb),
    .result_wb_o     (result_wb),
    .write_back_en_o (wb_en),
`ifdef WB_FWD_EN
    .fwd1_valid_o    (fwd1_valid),
    .fwd1_data_o     (fwd1_data),
    .fwd2_valid_o    (fwd2_valid),
    .fwd2_data_o     (fwd2_data),
`endif
    .count_o         (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [3:0] ed, input logic [31:0] er,
                       input logic mv, input logic [3:0] md, input logic [31:0] mdat);
    exe_valid = ev; exe_dest = ed; exe_result = er;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic chk_wb(input string tag, input logic [3:0] d, input logic [31:0] r);
    check({tag, "_en"}, 32'(wb_en), 32'd1);
    check({tag, "_dest"}, 32'(dest_wb), 32'(d));
    check({tag, "_res"}, result_wb, r);
  endtask

  initial begin
    rst_n = 1'b0;
    src1 = 4'd0;
    src2 = 4'd0;
    idle();
    tick();
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_wben", 32'(wb_en), 32'd0);
    check("rst_dest", 32'(dest_wb), 32'd0);
    check("rst_res", result_wb, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single execute result: visible on the write port one edge after acceptance
    src1 = 4'd3;
    drive(1'b1, 4'd3, 32'hDEAD0001, 1'b0, 4'd0, 32'd0);
    tick();
    idle();
    check("t1_count", 32'(count), 32'd1);
    check("t1_wben0", 32'(wb_en), 32'd0);
    check("t1_haz1", 32'(hazard1), 32'd1);
    tick();
    chk_wb("t1_wb", 4'd3, 32'hDEAD0001);
    check("t1_count0", 32'(count), 32'd0);
    check("t1_haz1_clr", 32'(hazard1), 32'd0);
    tick();
    check("t1_wben_off", 32'(wb_en), 32'd0);
    check("t1_dest_hold", 32'(dest_wb), 32'd3);

    // Same-cycle exe+mem to dest 5: load drains first
    src1 = 4'd5;
    drive(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22);
    #1;
    check("t2_mready", 32'(mem_ready), 32'd1);
    tick();
    idle();
    check("t2_count", 32'(count), 32'd2);
    check("t2_stall", 32'(stall), 32'd0);
    check("t2_haz1a", 32'(hazard1), 32'd1);
    tick();
    chk_wb("t2_wb1", 4'd5, 32'h22);
    check("t2_haz1b", 32'(hazard1), 32'd1);
    tick();
    chk_wb("t2_wb2", 4'd5, 32'h11);
    check("t2_haz1c", 32'(hazard1), 32'd0);
    tick();
    src1 = 4'd0;

    // Fill to 3: exe takes the last slot, load waits
    drive(1'b1, 4'd2, 32'hE1, 1'b1, 4'd1, 32'hA1);
    tick();
    check("t3_count_a", 32'(count), 32'd2);
    drive(1'b1, 4'd2, 32'hE2, 1'b1, 4'd1, 32'hA2);
    tick();
    chk_wb("t3_wb_b", 4'd1, 32'hA1);
    check("t3_count_b", 32'(count), 32'd3);
    check("t3_stall_b", 32'(stall), 32'd1);
    drive(1'b1, 4'd2, 32'hE3, 1'b1, 4'd1, 32'hA3);
    #1;
    check("t3_mready_full", 32'(mem_ready), 32'd0);
    tick();
    chk_wb("t3_wb_c", 4'd2, 32'hE1);
    check("t3_count_c", 32'(count), 32'd3);
    check("t3_stall_c", 32'(stall), 32'd1);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'hA3);
    #1;
    check("t3_mready_free", 32'(mem_ready), 32'd1);
    tick();
    idle();
    chk_wb("t3_wb_d", 4'd1, 32'hA2);
    check("t3_count_d", 32'(count), 32'd3);
    tick();
    chk_wb("t3_wb_e", 4'd2, 32'hE2);
    check("t3_stall_e", 32'(stall), 32'd0);
    tick();
    chk_wb("t3_wb_f", 4'd2, 32'hE3);
    tick();
    chk_wb("t3_wb_g", 4'd1, 32'hA3);
    check("t3_count_g", 32'(count), 32'd0);
    tick();
    check("t3_wben_h", 32'(wb_en), 32'd0);

    // Load to PC is consumed without enqueueing
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'hF, 32'h55);
    #1;
    check("t4_mready", 32'(mem_ready), 32'd1);
    tick();
    idle();
    check("t4_count", 32'(count), 32'd0);
    tick();
    check("t4_wben", 32'(wb_en), 32'd0);

    // Two pending dest-7 writes: youngest (0xB) is the forward candidate
    src2 = 4'd7;
    drive(1'b1, 4'd7, 32'hB, 1'b1, 4'd7, 32'hA);
    tick();
    idle();
    check("t5_count", 32'(count), 32'd2);
`ifdef WB_FWD_EN
    check("t5_fwd2_valid", 32'(fwd2_valid), 32'd1);
    check("t5_fwd2_data", fwd2_data, 32'hB);
    check("t5_haz2", 32'(hazard2), 32'd0);
`else
    check("t5_haz2", 32'(hazard2), 32'd1);
`endif
    tick();
    chk_wb("t5_wb1", 4'd7, 32'hA);
    tick();
    chk_wb("t5_wb2", 4'd7, 32'hB);
    tick();
    src2 = 4'd0;

    // Reset with three pending entries: nothing written afterwards
    drive(1'b1, 4'd8, 32'h81, 1'b1, 4'd9, 32'h91);
    tick();
    drive(1'b1, 4'd8, 32'h82, 1'b1, 4'd9, 32'h92);
    tick();
    idle();
    check("t6_count_pre", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count_rst", 32'(count), 32'd0);
    check("t6_wben_rst", 32'(wb_en), 32'd0);
    check("t6_stall_rst", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_wben_a", 32'(wb_en), 32'd0);
    tick();
    check("t6_wben_b", 32'(wb_en), 32'd0);
    check("t6_count_post", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
